// File: rtl/servant_wb_arbiter_n.sv
// servant_wb_arbiter_n: round-robin arbiter that multiplexes NM Wishbone masters onto one slave port.
// Define SERVANT_ARB_TIMEOUT_EN to compile in a bus timeout that force-acks a transfer the slave never answers.
module servant_wb_arbiter_n #(
   parameter int NM             = 2,
   parameter int AW             = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [NM*AW-1:0] i_m_adr,
   input  logic [NM*32-1:0] i_m_dat,
   input  logic [NM*4-1:0]  i_m_sel,
   input  logic [NM-1:0]    i_m_we,
   input  logic [NM-1:0]    i_m_cyc,
   output logic [31:0]      o_m_rdt,
   output logic [NM-1:0]    o_m_ack,
   output logic [AW-1:0]    o_s_adr,
   output logic [31:0]      o_s_dat,
   output logic [3:0]       o_s_sel,
   output logic             o_s_we,
   output logic             o_s_cyc,
   input  logic [31:0]      i_s_rdt,
   input  logic             i_s_ack,
   output logic [NM-1:0]    o_grant,
   output logic             o_timeout
);

   localparam int GW = (NM > 1) ? $clog2(NM) : 1;

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_BUSY = 1'b1;

   if (NM < 2 || NM > 8 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_param_check
      $error("servant_wb_arbiter_n: parameter out of range");
   end

   logic [0:0]    state;
   logic [GW-1:0] g;
   logic [GW-1:0] p;
   logic [GW-1:0] sel_idx;
   logic [GW-1:0] p_adv;
   logic          busy;
   logic          timeout_hit;
   logic          cyc_g;
   logic [AW-1:0] adr_g;
   logic [31:0]   dat_g;
   logic [3:0]    sel_g;
   logic          we_g;
   int            best_d;
   int            d;

   assign busy  = (state == S_BUSY);
   assign p_adv = (g == GW'(NM - 1)) ? '0 : g + 1'b1;

   // Pick the requesting master closest to p going upward (wrapping), so p itself has top priority.
   always_comb begin
      sel_idx = p;
      best_d  = NM;
      d       = 0;
      for (int k = 0; k < NM; k++) begin
         if (i_m_cyc[k]) begin
            d = (k + NM - int'(p)) % NM;
            if (d < best_d) begin
               best_d  = d;
               sel_idx = GW'(k);
            end
         end
      end
   end

   always_comb begin
      cyc_g = 1'b0;
      adr_g = '0;
      dat_g = '0;
      sel_g = '0;
      we_g  = 1'b0;
      for (int k = 0; k < NM; k++) begin
         if (g == GW'(k)) begin
            cyc_g = i_m_cyc[k];
            adr_g = i_m_adr[k*AW +: AW];
            dat_g = i_m_dat[k*32 +: 32];
            sel_g = i_m_sel[k*4 +: 4];
            we_g  = i_m_we[k];
         end
      end
   end

   // A forced timeout ack hides the slave's data and drops the slave cycle for that one beat.
   always_comb begin
      o_s_adr = busy ? adr_g : '0;
      o_s_dat = busy ? dat_g : '0;
      o_s_sel = busy ? sel_g : '0;
      o_s_we  = busy & we_g;
      o_s_cyc = busy & cyc_g & ~timeout_hit;
      o_m_rdt = (busy && !timeout_hit) ? i_s_rdt : '0;
      o_m_ack = '0;
      for (int k = 0; k < NM; k++) begin
         o_m_ack[k] = busy && (g == GW'(k)) && (i_s_ack || timeout_hit);
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state   <= S_IDLE;
         g       <= '0;
         p       <= '0;
         o_grant <= '0;
      end else if (state == S_IDLE) begin
         if (|i_m_cyc) begin
            state   <= S_BUSY;
            g       <= sel_idx;
            o_grant <= {{(NM-1){1'b0}}, 1'b1} << sel_idx;
         end
      end else begin
         if (i_s_ack || timeout_hit) begin
            state   <= S_IDLE;
            o_grant <= '0;
            p       <= p_adv;
         end else if (!cyc_g) begin
            state   <= S_IDLE;
            o_grant <= '0;
         end
      end
   end

`ifdef SERVANT_ARB_TIMEOUT_EN
   logic [15:0] to_cnt;
   logic        to_flag;

   assign timeout_hit = busy && !i_s_ack && (to_cnt == 16'(TIMEOUT_CYCLES));
   assign o_timeout   = to_flag;

   // Holding the counter at zero while idle guarantees it starts from zero on every BUSY entry.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         to_cnt  <= '0;
         to_flag <= 1'b0;
      end else begin
         if (state == S_IDLE) begin
            to_cnt <= '0;
         end else if (!i_s_ack) begin
            to_cnt <= to_cnt + 16'd1;
         end
         if (timeout_hit) begin
            to_flag <= 1'b1;
         end
      end
   end
`else
   assign timeout_hit = 1'b0;
   assign o_timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_servant_wb_arbiter_n.sv
// tb_servant_wb_arbiter_n: directed scenarios plus a randomized run against a transaction-level arbiter model.
module tb_servant_wb_arbiter_n;

   localparam int NM = 4;
   localparam int AW = 32;
   localparam int TO = 4;

   logic             clk = 1'b0;
   logic             rst;
   logic [NM*AW-1:0] m_adr;
   logic [NM*32-1:0] m_dat;
   logic [NM*4-1:0]  m_sel;
   logic [NM-1:0]    m_we;
   logic [NM-1:0]    m_cyc;
   logic [31:0]      m_rdt;
   logic [NM-1:0]    m_ack;
   logic [AW-1:0]    s_adr;
   logic [31:0]      s_dat;
   logic [3:0]       s_sel;
   logic             s_we;
   logic             s_cyc;
   logic [31:0]      s_rdt;
   logic             s_ack;
   logic [NM-1:0]    grant;
   logic             timeout;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   servant_wb_arbiter_n #(.NM(NM), .AW(AW), .TIMEOUT_CYCLES(TO)) dut (
      .i_clk(clk), .i_rst(rst),
      .i_m_adr(m_adr), .i_m_dat(m_dat), .i_m_sel(m_sel), .i_m_we(m_we), .i_m_cyc(m_cyc),
      .o_m_rdt(m_rdt), .o_m_ack(m_ack),
      .o_s_adr(s_adr), .o_s_dat(s_dat), .o_s_sel(s_sel), .o_s_we(s_we), .o_s_cyc(s_cyc),
      .i_s_rdt(s_rdt), .i_s_ack(s_ack),
      .o_grant(grant), .o_timeout(timeout)
   );

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "[TB] watchdog");
   end

   task automatic do_reset();
      @(negedge clk);
      rst   = 1'b1;
      m_cyc = '0;
      s_ack = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst   = 1'b1;
      m_cyc = '1;
      s_ack = 1'b1;
      s_rdt = 32'hA5A5_5A5A;
      @(negedge clk);
      #1;
      total++; if (grant !== '0)   begin bad++; $display("[TB] FAIL rst_grant got=%b want=0", grant); end
      total++; if (s_cyc !== 1'b0) begin bad++; $display("[TB] FAIL rst_scyc got=%b want=0", s_cyc); end
      total++; if (m_ack !== '0)   begin bad++; $display("[TB] FAIL rst_ack got=%b want=0", m_ack); end
      total++; if (timeout !== 1'b0) begin bad++; $display("[TB] FAIL rst_timeout got=%b want=0", timeout); end
      total++; if (m_rdt !== 32'h0) begin bad++; $display("[TB] FAIL rst_rdt got=%h want=0", m_rdt); end
      rst   = 1'b0;
      m_cyc = '0;
      s_ack = 1'b0;
   endtask

   task automatic test_single_read();
      do_reset();
      @(negedge clk);
      m_cyc = 4'b0001;
      m_adr[0 +: AW] = 32'h0000_0100;
      m_we[0] = 1'b0;
      #1;
      total++; if (s_cyc !== 1'b0) begin bad++; $display("[TB] FAIL rd_idle_scyc got=%b want=0", s_cyc); end
      total++; if (m_ack !== '0)   begin bad++; $display("[TB] FAIL rd_idle_ack got=%b want=0", m_ack); end
      @(negedge clk); #1;
      total++; if (s_cyc !== 1'b1) begin bad++; $display("[TB] FAIL rd_scyc got=%b want=1", s_cyc); end
      total++; if (s_adr !== 32'h100) begin bad++; $display("[TB] FAIL rd_adr got=%h want=100", s_adr); end
      total++; if (grant !== 4'b0001) begin bad++; $display("[TB] FAIL rd_grant got=%b want=0001", grant); end
      @(negedge clk); #1;
      total++; if (m_ack !== '0) begin bad++; $display("[TB] FAIL rd_wait_ack got=%b want=0", m_ack); end
      @(negedge clk);
      s_ack = 1'b1;
      s_rdt = 32'hDEAD_BEEF;
      #1;
      total++; if (m_ack !== 4'b0001) begin bad++; $display("[TB] FAIL rd_ack got=%b want=0001", m_ack); end
      total++; if (m_rdt !== 32'hDEAD_BEEF) begin bad++; $display("[TB] FAIL rd_rdt got=%h want=deadbeef", m_rdt); end
      @(negedge clk);
      m_cyc = '0;
      s_ack = 1'b0;
      #1;
      total++; if (grant !== '0)   begin bad++; $display("[TB] FAIL rd_after_grant got=%b want=0", grant); end
      total++; if (s_cyc !== 1'b0) begin bad++; $display("[TB] FAIL rd_after_scyc got=%b want=0", s_cyc); end
      total++; if (m_rdt !== 32'h0) begin bad++; $display("[TB] FAIL rd_after_rdt got=%h want=0", m_rdt); end
   endtask

   task automatic test_round_robin();
      logic [NM-1:0] exp;
      do_reset();
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         m_cyc = '1;
         s_ack = 1'b1;
         #1;
         exp = (c % 2 == 1) ? (NM'(1) << (((c - 1) / 2) % NM)) : '0;
         total++; if (grant !== exp) begin bad++; $display("[TB] FAIL rr_grant c=%0d got=%b want=%b", c, grant, exp); end
         total++; if (m_ack !== exp) begin bad++; $display("[TB] FAIL rr_ack c=%0d got=%b want=%b", c, m_ack, exp); end
      end
      @(negedge clk);
      m_cyc = '0;
      s_ack = 1'b0;
   endtask

   task automatic test_write_m1();
      do_reset();
      @(negedge clk);
      m_adr[0 +: AW]  = $urandom;
      m_dat[0 +: 32]  = $urandom;
      m_sel[0 +: 4]   = 4'hA;
      m_adr[AW +: AW] = 32'h8000_0000;
      m_dat[32 +: 32] = 32'h0000_0001;
      m_sel[4 +: 4]   = 4'hF;
      m_we  = 4'b0011;
      m_cyc = 4'b0010;
      #1;
      total++; if (m_ack[0] !== 1'b0) begin bad++; $display("[TB] FAIL wr_ack0_idle got=%b want=0", m_ack[0]); end
      @(negedge clk); #1;
      total++; if (s_adr !== 32'h8000_0000) begin bad++; $display("[TB] FAIL wr_adr got=%h want=80000000", s_adr); end
      total++; if (s_dat !== 32'h1) begin bad++; $display("[TB] FAIL wr_dat got=%h want=1", s_dat); end
      total++; if (s_sel !== 4'hF) begin bad++; $display("[TB] FAIL wr_sel got=%h want=f", s_sel); end
      total++; if (s_we !== 1'b1)  begin bad++; $display("[TB] FAIL wr_we got=%b want=1", s_we); end
      total++; if (grant !== 4'b0010) begin bad++; $display("[TB] FAIL wr_grant got=%b want=0010", grant); end
      @(negedge clk);
      s_ack = 1'b1;
      #1;
      total++; if (m_ack !== 4'b0010) begin bad++; $display("[TB] FAIL wr_ack got=%b want=0010", m_ack); end
      @(negedge clk);
      m_cyc = '0;
      s_ack = 1'b0;
      m_we  = '0;
   endtask

   task automatic test_drop();
      do_reset();
      @(negedge clk);
      m_cyc = 4'b0001;
      @(negedge clk); #1;
      total++; if (grant !== 4'b0001) begin bad++; $display("[TB] FAIL drop_grant got=%b want=0001", grant); end
      @(negedge clk);
      m_cyc = '0;
      #1;
      total++; if (m_ack !== '0)   begin bad++; $display("[TB] FAIL drop_ack got=%b want=0", m_ack); end
      total++; if (s_cyc !== 1'b0) begin bad++; $display("[TB] FAIL drop_scyc got=%b want=0", s_cyc); end
      @(negedge clk);
      m_cyc = 4'b0011;
      #1;
      total++; if (grant !== '0) begin bad++; $display("[TB] FAIL drop_idle_grant got=%b want=0", grant); end
      @(negedge clk);
      s_ack = 1'b1;
      #1;
      total++; if (grant !== 4'b0001) begin bad++; $display("[TB] FAIL drop_pointer got=%b want=0001", grant); end
      @(negedge clk);
      m_cyc = '0;
      s_ack = 1'b0;
   endtask

   task automatic test_timeout();
      do_reset();
      @(negedge clk);
      m_cyc = 4'b0100;
      s_ack = 1'b0;
`ifdef SERVANT_ARB_TIMEOUT_EN
      for (int c = 1; c <= TO; c++) begin
         @(negedge clk); #1;
         total++; if (m_ack !== '0) begin bad++; $display("[TB] FAIL to_early_ack c=%0d got=%b want=0", c, m_ack); end
         total++; if (s_cyc !== 1'b1) begin bad++; $display("[TB] FAIL to_early_scyc c=%0d got=%b want=1", c, s_cyc); end
      end
      @(negedge clk);
      s_rdt = 32'h1234_5678;
      #1;
      total++; if (m_ack !== 4'b0100) begin bad++; $display("[TB] FAIL to_ack got=%b want=0100", m_ack); end
      total++; if (m_rdt !== 32'h0) begin bad++; $display("[TB] FAIL to_rdt got=%h want=0", m_rdt); end
      total++; if (s_cyc !== 1'b0) begin bad++; $display("[TB] FAIL to_scyc got=%b want=0", s_cyc); end
      @(negedge clk);
      m_cyc = '0;
      #1;
      total++; if (grant !== '0) begin bad++; $display("[TB] FAIL to_idle_grant got=%b want=0", grant); end
      for (int c = 0; c < 4; c++) begin
         total++; if (timeout !== 1'b1) begin bad++; $display("[TB] FAIL to_sticky c=%0d got=%b want=1", c, timeout); end
         @(negedge clk); #1;
      end
      do_reset();
      #1;
      total++; if (timeout !== 1'b0) begin bad++; $display("[TB] FAIL to_clear got=%b want=0", timeout); end
`else
      for (int c = 1; c <= 120; c++) begin
         @(negedge clk); #1;
         total++; if (s_cyc !== 1'b1 || m_ack !== '0) begin bad++; $display("[TB] FAIL hold_busy c=%0d scyc=%b ack=%b want scyc=1 ack=0", c, s_cyc, m_ack); end
         total++; if (timeout !== 1'b0) begin bad++; $display("[TB] FAIL hold_timeout c=%0d got=%b want=0", c, timeout); end
      end
      @(negedge clk);
      m_cyc = '0;
`endif
   endtask

   task automatic test_reset_busy();
      do_reset();
      @(negedge clk);
      m_cyc = 4'b0010;
      @(negedge clk);
      s_ack = 1'b1;
      @(negedge clk);
      s_ack = 1'b0;
      m_cyc = 4'b1000;
      @(negedge clk); #1;
      total++; if (grant !== 4'b1000) begin bad++; $display("[TB] FAIL rb_grant got=%b want=1000", grant); end
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst   = 1'b0;
      m_cyc = '1;
      #1;
      total++; if (s_cyc !== 1'b0) begin bad++; $display("[TB] FAIL rb_scyc got=%b want=0", s_cyc); end
      total++; if (grant !== '0)   begin bad++; $display("[TB] FAIL rb_grant0 got=%b want=0", grant); end
      total++; if (m_ack !== '0)   begin bad++; $display("[TB] FAIL rb_ack got=%b want=0", m_ack); end
      @(negedge clk); #1;
      total++; if (grant !== 4'b0001) begin bad++; $display("[TB] FAIL rb_pointer got=%b want=0001", grant); end
      @(negedge clk);
      m_cyc = '0;
   endtask

   // Transaction-level model: one owner at a time, served in rotation starting from the pointer.
   task automatic test_random();
      int            mbusy, mg, mp, mcnt, mto;
      bit            to_now;
      logic [NM-1:0] exp_ack, exp_grant, last_ack;
      logic          exp_scyc;
      logic [31:0]   exp_rdt;
      logic [AW-1:0] exp_adr;
      do_reset();
      mbusy = 0; mg = 0; mp = 0; mcnt = 0; mto = 0;
      last_ack = '0;
      for (int c = 0; c < 300; c++) begin
         @(negedge clk);
         for (int k = 0; k < NM; k++) begin
            if (m_cyc[k] && (last_ack[k] || $urandom_range(15) == 0)) begin
               m_cyc[k] = 1'b0;
            end else if (!m_cyc[k] && $urandom_range(2) == 0) begin
               m_cyc[k] = 1'b1;
               m_adr[k*AW +: AW] = $urandom;
               m_dat[k*32 +: 32] = $urandom;
               m_sel[k*4 +: 4]   = 4'($urandom);
               m_we[k]           = 1'($urandom);
            end
         end
         s_ack = ($urandom_range(2) == 0);
         s_rdt = $urandom;
         #1;
         to_now = 1'b0;
`ifdef SERVANT_ARB_TIMEOUT_EN
         to_now = (mbusy != 0) && !s_ack && (mcnt == TO);
`endif
         if (mbusy != 0) begin
            exp_grant = NM'(1) << mg;
            exp_scyc  = m_cyc[mg] && !to_now;
            exp_ack   = (s_ack || to_now) ? exp_grant : '0;
            exp_rdt   = to_now ? 32'h0 : s_rdt;
            exp_adr   = m_adr[mg*AW +: AW];
         end else begin
            exp_grant = '0;
            exp_scyc  = 1'b0;
            exp_ack   = '0;
            exp_rdt   = 32'h0;
            exp_adr   = '0;
         end
         total++; if (grant !== exp_grant) begin bad++; $display("[TB] FAIL rnd_grant c=%0d got=%b want=%b", c, grant, exp_grant); end
         total++; if (s_cyc !== exp_scyc)  begin bad++; $display("[TB] FAIL rnd_scyc c=%0d got=%b want=%b", c, s_cyc, exp_scyc); end
         total++; if (m_ack !== exp_ack)   begin bad++; $display("[TB] FAIL rnd_ack c=%0d got=%b want=%b", c, m_ack, exp_ack); end
         total++; if (m_rdt !== exp_rdt)   begin bad++; $display("[TB] FAIL rnd_rdt c=%0d got=%h want=%h", c, m_rdt, exp_rdt); end
         total++; if (s_adr !== exp_adr)   begin bad++; $display("[TB] FAIL rnd_adr c=%0d got=%h want=%h", c, s_adr, exp_adr); end
         total++; if (timeout !== 1'(mto)) begin bad++; $display("[TB] FAIL rnd_timeout c=%0d got=%b want=%0d", c, timeout, mto); end
         last_ack = exp_ack;
         if (mbusy == 0) begin
            for (int i = 0; i < NM; i++) begin
               if (mbusy == 0 && m_cyc[(mp + i) % NM]) begin
                  mg    = (mp + i) % NM;
                  mbusy = 1;
                  mcnt  = 0;
               end
            end
         end else if (s_ack) begin
            mbusy = 0;
            mp    = (mg + 1) % NM;
         end else if (to_now) begin
            mbusy = 0;
            mp    = (mg + 1) % NM;
            mto   = 1;
         end else if (!m_cyc[mg]) begin
            mbusy = 0;
         end else begin
            mcnt++;
         end
      end
      @(negedge clk);
      m_cyc = '0;
      s_ack = 1'b0;
   endtask

   initial begin
      rst   = 1'b1;
      m_adr = '0;
      m_dat = '0;
      m_sel = '0;
      m_we  = '0;
      m_cyc = '0;
      s_rdt = '0;
      s_ack = 1'b0;
      test_reset();
      test_single_read();
      test_round_robin();
      test_write_m1();
      test_drop();
      test_timeout();
      test_reset_busy();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
